// File: rtl/adder_pipelined_if.sv
// Operand/result handshake bundle for adder_pipelined.
// master drives operands and o_ready; slave is the adder itself.
interface adder_pipelined_if #(
  parameter int unsigned N = 32
) ();
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic         i_c_in;
  logic         i_sub;
  logic         o_valid;
  logic         o_ready;
  logic [N-1:0] o_sum;
  logic         o_c_out;
  logic         o_overflow;

  modport master (
    output i_valid, i_a, i_b, i_c_in, i_sub, o_ready,
    input  i_ready, o_valid, o_sum, o_c_out, o_overflow
  );

  modport slave (
    input  i_valid, i_a, i_b, i_c_in, i_sub, o_ready,
    output i_ready, o_valid, o_sum, o_c_out, o_overflow
  );
endinterface

// File: rtl/adder_pipelined.sv
// Pipelined N-bit add/subtract: one CHUNK-bit ripple slice per register stage,
// latency N/CHUNK, full-rate valid/ready with whole-pipe stall on backpressure.
module adder_pipelined #(
  parameter int unsigned N     = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic              clk,
  input logic              rst_n,
  adder_pipelined_if.slave bus
);
  localparam int unsigned STAGES = N / CHUNK;

  logic         adv;
  logic [N-1:0] b_prep;
  logic         cin_prep;

  // Subtract as a + ~b + 1; caller's carry-in is ignored in that mode.
  assign b_prep   = bus.i_sub ? ~bus.i_b : bus.i_b;
  assign cin_prep = bus.i_sub | bus.i_c_in;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned InW  = N - s * CHUNK;
    localparam int unsigned ResW = (s + 1) * CHUNK;

    logic [InW-1:0]  a_in;
    logic [InW-1:0]  b_in;
    logic            c_in;
    logic            v_in;
    logic [CHUNK:0]  slice;
    logic [ResW-1:0] res_d;
    logic [ResW-1:0] res_q;
    logic            c_q;
    logic            v_q;

    // Unprocessed operand bits travel right-aligned, so the active slice is always [CHUNK-1:0].
    if (s == 0) begin : g_head
      assign a_in  = bus.i_a;
      assign b_in  = b_prep;
      assign c_in  = cin_prep;
      assign v_in  = bus.i_valid;
      assign res_d = slice[CHUNK-1:0];
    end else begin : g_body
      assign a_in  = g_stage[s-1].g_fwd.a_q;
      assign b_in  = g_stage[s-1].g_fwd.b_q;
      assign c_in  = g_stage[s-1].c_q;
      assign v_in  = g_stage[s-1].v_q;
      assign res_d = {slice[CHUNK-1:0], g_stage[s-1].res_q};
    end

    assign slice = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q <= '0;
        c_q   <= 1'b0;
        v_q   <= 1'b0;
      end else if (adv) begin
        res_q <= res_d;
        c_q   <= slice[CHUNK];
        v_q   <= v_in;
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      logic [InW-CHUNK-1:0] a_q;
      logic [InW-CHUNK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[InW-1:CHUNK];
          b_q <= b_in[InW-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // a^b^sum at the MSB recovers the carry into bit N-1.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ slice[CHUNK-1] ^ slice[CHUNK];
        end
      end
    end
  end

  assign adv            = !g_stage[STAGES-1].v_q || bus.o_ready;
  assign bus.i_ready    = adv;
  assign bus.o_valid    = g_stage[STAGES-1].v_q;
  assign bus.o_sum      = g_stage[STAGES-1].res_q;
  assign bus.o_c_out    = g_stage[STAGES-1].c_q;
  assign bus.o_overflow = g_stage[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_adder_pipelined.sv
// Randomised and directed bench for adder_pipelined against an arithmetic reference model,
// covering 32/8 in depth plus streaming on the 16/4 and 8/8 configurations.
module tb_adder_pipelined;
  localparam int unsigned N      = 32;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned STAGES = N / CHUNK;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [63:0] sum;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial forever #5 clk = ~clk;

  adder_pipelined_if #(.N(32)) bus32 ();
  adder_pipelined_if #(.N(16)) bus16 ();
  adder_pipelined_if #(.N(8))  bus8 ();

  adder_pipelined #(.N(32), .CHUNK(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  adder_pipelined #(.N(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  adder_pipelined #(.N(8),  .CHUNK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic; overflow from operand/result signs.
  function automatic res_t model(input int unsigned n, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    res_t        r;
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bb;
    logic [64:0] full;
    mask   = (64'd1 << n) - 64'd1;
    am     = a & mask;
    bb     = (sub ? ~b : b) & mask;
    full   = {1'b0, am} + {1'b0, bb} + {64'd0, (sub | cin)};
    r.sum  = full[63:0] & mask;
    r.cout = full[n];
    r.ovf  = (am[n-1] == bb[n-1]) && (r.sum[n-1] != am[n-1]);
    return r;
  endfunction

  // Scoreboard for the 32-bit instance.
  res_t exp_q[$];
  int   acc_q[$];
  int   cyc     = 0;
  bit   lat_chk = 1'b0;
  bit   hold_v  = 1'b0;
  res_t hold_r;
  int   n_out   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : mon
    res_t e;
    int   c;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (hold_v) begin
          check("hold_valid", 64'(bus32.o_valid), 64'd1);
          check("hold_data", 64'({bus32.o_overflow, bus32.o_c_out, bus32.o_sum}),
                64'({hold_r.ovf, hold_r.cout, hold_r.sum[31:0]}));
        end
        hold_v = 1'b0;
        if (bus32.o_valid) begin
          if (!bus32.o_ready) begin
            hold_v      = 1'b1;
            hold_r.sum  = 64'(bus32.o_sum);
            hold_r.cout = bus32.o_c_out;
            hold_r.ovf  = bus32.o_overflow;
          end else if (exp_q.size() == 0) begin
            check("spurious_beat", 64'(bus32.o_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            c = acc_q.pop_front();
            check("sum", 64'(bus32.o_sum), e.sum);
            check("c_out", 64'(bus32.o_c_out), 64'(e.cout));
            check("overflow", 64'(bus32.o_overflow), 64'(e.ovf));
            if (lat_chk) check("latency", 64'(cyc - c), 64'(STAGES));
            n_out++;
          end
        end
        if (bus32.i_valid && bus32.i_ready) begin
          exp_q.push_back(model(N, 64'(bus32.i_a), 64'(bus32.i_b), bus32.i_c_in, bus32.i_sub));
          acc_q.push_back(cyc);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic drive_beat(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic sub);
    int w = 0;
    bus32.i_a     = a;
    bus32.i_b     = b;
    bus32.i_c_in  = cin;
    bus32.i_sub   = sub;
    bus32.i_valid = 1'b1;
    @(negedge clk);
    while (!bus32.i_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w == 50) check("accept_timeout", 64'(bus32.i_ready), 64'd1);
    @(posedge clk);
    #1;
    bus32.i_valid = 1'b0;
  endtask

  task automatic rand_beat();
    drive_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b, input logic cin,
                     input logic sub, input logic [31:0] esum, input logic ecout,
                     input logic eovf);
    int n = 1;
    drive_beat(a, b, cin, sub);
    while (!bus32.o_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(STAGES));
    check({tag, "_sum"}, 64'(bus32.o_sum), 64'(esum));
    check({tag, "_c_out"}, 64'(bus32.o_c_out), 64'(ecout));
    check({tag, "_overflow"}, 64'(bus32.o_overflow), 64'(eovf));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Lock-step streaming on the 16/4 (latency 4) and 8/8 (latency 1) instances.
  task automatic run_small();
    res_t q16[$];
    res_t q8[$];
    int   c16[$];
    int   c8[$];
    int   k16 = 0;
    int   k8  = 0;
    res_t e;
    for (int i = 0; i < 28; i++) begin
      @(posedge clk);
      #1;
      if (i < 20) begin
        bus16.i_a = 16'($urandom); bus16.i_b = 16'($urandom);
        bus16.i_c_in = 1'($urandom_range(0, 1)); bus16.i_sub = 1'($urandom_range(0, 1));
        bus16.i_valid = 1'b1;
        q16.push_back(model(16, 64'(bus16.i_a), 64'(bus16.i_b), bus16.i_c_in, bus16.i_sub));
        c16.push_back(i);
        bus8.i_a = 8'($urandom); bus8.i_b = 8'($urandom);
        bus8.i_c_in = 1'($urandom_range(0, 1)); bus8.i_sub = 1'($urandom_range(0, 1));
        bus8.i_valid = 1'b1;
        q8.push_back(model(8, 64'(bus8.i_a), 64'(bus8.i_b), bus8.i_c_in, bus8.i_sub));
        c8.push_back(i);
      end else begin
        bus16.i_valid = 1'b0;
        bus8.i_valid  = 1'b0;
      end
      @(negedge clk);
      check("s16_ready", 64'(bus16.i_ready), 64'd1);
      check("s8_ready", 64'(bus8.i_ready), 64'd1);
      if (bus16.o_valid) begin
        if (q16.size() == 0) check("s16_spurious", 64'(bus16.o_valid), 64'd0);
        else begin
          e = q16.pop_front();
          check("s16_sum", 64'(bus16.o_sum), e.sum);
          check("s16_c_out", 64'(bus16.o_c_out), 64'(e.cout));
          check("s16_overflow", 64'(bus16.o_overflow), 64'(e.ovf));
          check("s16_latency", 64'(i - c16.pop_front()), 64'd4);
          k16++;
        end
      end
      if (bus8.o_valid) begin
        if (q8.size() == 0) check("s8_spurious", 64'(bus8.o_valid), 64'd0);
        else begin
          e = q8.pop_front();
          check("s8_sum", 64'(bus8.o_sum), e.sum);
          check("s8_c_out", 64'(bus8.o_c_out), 64'(e.cout));
          check("s8_overflow", 64'(bus8.o_overflow), 64'(e.ovf));
          check("s8_latency", 64'(i - c8.pop_front()), 64'd1);
          k8++;
        end
      end
    end
    check("s16_count", 64'(k16), 64'd20);
    check("s8_count", 64'(k8), 64'd20);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   base;
    res_t r;
    bus32.i_valid = 1'b0; bus32.i_a = '0; bus32.i_b = '0; bus32.i_c_in = 1'b0;
    bus32.i_sub = 1'b0; bus32.o_ready = 1'b1;
    bus16.i_valid = 1'b0; bus16.i_a = '0; bus16.i_b = '0; bus16.i_c_in = 1'b0;
    bus16.i_sub = 1'b0; bus16.o_ready = 1'b1;
    bus8.i_valid = 1'b0; bus8.i_a = '0; bus8.i_b = '0; bus8.i_c_in = 1'b0;
    bus8.i_sub = 1'b0; bus8.o_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_o_valid", 64'(bus32.o_valid), 64'd0);
    check("rst_o_sum", 64'(bus32.o_sum), 64'd0);
    check("rst_c_out", 64'(bus32.o_c_out), 64'd0);
    check("rst_overflow", 64'(bus32.o_overflow), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_i_ready", 64'(bus32.i_ready), 64'd1);

    run_small();
    @(posedge clk);
    #1;

    dir("add_basic", 32'h5, 32'h3, 1'b1, 1'b0, 32'h9, 1'b0, 1'b0);
    dir("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    dir("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    dir("sub_borrow", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    dir("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    dir("sub_cin_ignored", 32'hA, 32'h3, 1'b0, 1'b1, 32'h7, 1'b1, 1'b0);

    // Back-to-back stream with latency checked on every beat.
    base    = n_out;
    lat_chk = 1'b1;
    repeat (20) rand_beat();
    wait_drain();
    lat_chk = 1'b0;
    check("stream_count", 64'(n_out - base), 64'd20);

    // Stall the consumer for three cycles mid-stream.
    base = n_out;
    fork
      begin
        repeat (12) rand_beat();
      end
      begin
        int w = 0;
        @(negedge clk);
        while (!bus32.o_valid && w < 30) begin
          @(negedge clk);
          w++;
        end
        check("bp_reach_valid", 64'(bus32.o_valid), 64'd1);
        @(posedge clk);
        #1 bus32.o_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_i_ready", 64'(bus32.i_ready), 64'd0);
        end
        @(posedge clk);
        #1 bus32.o_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_count", 64'(n_out - base), 64'd12);

    // Reset with the pipe full; the first beat sits at the output.
    repeat (4) rand_beat();
    check("pre_rst_valid", 64'(bus32.o_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    hold_v = 1'b0;
    check("midrst_o_valid", 64'(bus32.o_valid), 64'd0);
    check("midrst_o_sum", 64'(bus32.o_sum), 64'd0);
    check("midrst_c_out", 64'(bus32.o_c_out), 64'd0);
    check("midrst_overflow", 64'(bus32.o_overflow), 64'd0);
    check("midrst_i_ready", 64'(bus32.i_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_stale", 64'(bus32.o_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    r = model(N, 64'h1234_5678, 64'h9ABC_DEF0, 1'b1, 1'b0);
    dir("post_rst", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, r.sum[31:0], r.cout, r.ovf);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_pipelined.md
Name: adder_pipelined

Overview:
- Parametrised, pipelined N-bit add/subtract unit; successor to the team's combinational ripple-carry adder.
- Splits the carry chain into CHUNK-bit slices, with one register stage per slice. This gives one result per cycle at N/CHUNK cycles of latency.
- Adds a per-transaction subtract mode, a signed-overflow flag and a valid/ready handshake on both sides.
- Sits between operand sources (register file / ALU operand muxes) and any consumer that can apply backpressure.

Parameters:
- N, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per pipeline stage; 1 <= CHUNK <= N.
- STAGES (localparam), N/CHUNK, number of register stages and the latency in cycles.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  operand beat valid.
- i_ready  output  1  block can accept a beat this cycle.
- i_a  input  N  operand a (two's complement or unsigned).
- i_b  input  N  operand b.
- i_c_in  input  1  carry in; ignored when i_sub=1.
- i_sub  input  1  1: compute a - b; 0: compute a + b + c_in.
- o_valid  output  1  result beat valid.
- o_ready  input  1  downstream accepts the result this cycle.
- o_sum  output  N  result.
- o_c_out  output  1  carry out of bit N-1; for subtract, 1 = no borrow.
- o_overflow  output  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits clear and all stage data registers clear;
  - o_valid=0, o_sum=0, o_c_out=0, o_overflow=0.
  - i_ready becomes 1 after reset, since the pipe is empty.
- Reset mid-operation discards every in-flight beat; nothing is emitted for those beats after rst_n rises.
- Operand prep at the input:
  - i_sub=0: b' = i_b, cin = i_c_in.
  - i_sub=1: b' = ~i_b, cin = 1.
- Stage k (k = 1..STAGES) resolves bits [k*CHUNK-1 : (k-1)*CHUNK]:
  - it adds a and b' slices with the carry registered by stage k-1 (stage 1 uses cin);
  - it registers the sum slice, the carry out, the not-yet-processed upper a/b' bits and the lower sum bits already resolved;
  - each slice is a plain ripple add, with no carry lookahead required.
- The last stage also registers the carry into bit N-1 for o_overflow.
- o_sum, o_c_out and o_overflow come straight from the last stage's registers; there is no combinational path from inputs to outputs.
- Advance rule: adv = !o_valid || o_ready.
  - i_ready = adv (combinational from o_valid and o_ready only).
  - When adv=1, every stage captures its predecessor, and stage 1 captures the input with valid = i_valid.
  - When adv=0, all stages hold, including bubbles; bubbles are not compressed.
- Latency and throughput:
  - A beat accepted in cycle t (i_valid & i_ready at the edge ending cycle t) gives o_valid=1 in cycle t+STAGES when there are no stalls. Each stall cycle adds one.
  - Throughput is one beat per cycle while o_ready stays high.
- Output hold: while o_valid=1 and o_ready=0, o_sum, o_c_out and o_overflow stay stable and no beat is lost or duplicated.
- Simultaneous accept and emit in one cycle (i_valid, i_ready, o_valid, o_ready all 1) is legal; the pipe shifts by one.
- When i_valid=0 and adv=1, a bubble enters stage 1. The data registers of an invalid stage are don't-care internally, but o_sum must not glitch while o_valid=1.
- Arithmetic is modulo 2^N.
- STAGES=1 (CHUNK=N) gives a single-register adder with latency 1.

Test Plan:
- Basic add, N=32, CHUNK=8: a=0x0000_0005, b=0x0000_0003, c_in=1, sub=0 accepted in cycle 0 -> cycle 4: o_valid=1, o_sum=0x0000_0009, c_out=0, overflow=0.
- Cross-chunk carry: a=0xFFFF_FFFF, b=0x0000_0001, c_in=0 -> o_sum=0x0000_0000, c_out=1, overflow=0. Separately, a=0x7FFF_FFFF, b=1 -> o_sum=0x8000_0000, c_out=0, overflow=1.
- Subtract:
  - a=5, b=7, sub=1, c_in=1 -> o_sum=0xFFFF_FFFE, c_out=0, overflow=0.
  - a=0x8000_0000, b=1, sub=1 -> o_sum=0x7FFF_FFFF, c_out=1, overflow=1.
- Streaming: 20 back-to-back random beats, o_ready=1 -> results in order, one per cycle, first at cycle 4, all matching the golden model of a + b' + cin.
- Backpressure: stream beats and drop o_ready for 3 cycles while o_valid=1 -> i_ready=0 for those cycles, o_sum held stable, no beats lost or duplicated; order is preserved once o_ready returns.
- Reset mid-stream, plus a parameter sweep:
  - assert rst_n=0 with 3 beats in flight -> o_valid=0 and outputs 0 immediately; no stale beat after release; the first new beat has latency STAGES.
  - rerun the streaming test with (N=16, CHUNK=4) and (N=8, CHUNK=8).
